uart_rx_frame_ctrl: RTL and testbench

- Receive-side frame controller of the UART RX path.
- Oversamples RX_IN at Prescale× bit rate, detects start, majority-samples each bit, deserializes 8 data bits LSB-first.
- Drives sampled_bit/P_DATA/par_chk_en into the downstream parity checker and consumes its par_err.
- Checks stop bit; issues a one-cycle data_valid pulse for clean frames.

---
 rtl/uart_rx_frame_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: start detection, 3-point majority sampling, LSB-first
// deserialization, parity-check handshake and stop-bit check with a data_valid pulse.
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  par_err,
    output logic                  par_typ,
    output logic                  par_chk_en,
    output logic                  sampled_bit,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err_flag,
    output logic                  stp_err
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [PRESCALE_W-1:0]   presc_q, presc_d;
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic [2:0]              samp_q, samp_d;
    logic                    sampled_bit_q, sampled_bit_d;
    logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    par_err_flag_q, par_err_flag_d;
    logic                    stp_err_q, stp_err_d;
    logic                    par_chk_en_c;

    logic [PRESCALE_W-1:0]   half, ec_last, ec_s0, ec_s1, ec_s2, ec_vote, ec_act;
    logic                    last_edge, begin_frame;

    always_comb begin
        half    = presc_q >> 1;
        ec_last = presc_q - PRESCALE_W'(1);
        ec_s0   = half - PRESCALE_W'(1);
        ec_s1   = half;
        ec_s2   = half + PRESCALE_W'(1);
        ec_vote = half + PRESCALE_W'(2);
        ec_act  = half + PRESCALE_W'(3);
        last_edge = (edge_cnt_q == ec_last);
    end

    always_comb begin
        state_d        = state_q;
        edge_cnt_d     = edge_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        presc_d        = presc_q;
        par_en_d       = par_en_q;
        par_typ_d      = par_typ_q;
        samp_d         = samp_q;
        sampled_bit_d  = sampled_bit_q;
        p_data_d       = p_data_q;
        data_valid_d   = 1'b0;
        par_err_flag_d = par_err_flag_q;
        stp_err_d      = stp_err_q;
        par_chk_en_c   = 1'b0;
        begin_frame    = 1'b0;

        if (state_q != ST_IDLE) begin
            edge_cnt_d = last_edge ? '0 : edge_cnt_q + PRESCALE_W'(1);
            if (edge_cnt_q == ec_s0) samp_d[0] = RX_IN;
            if (edge_cnt_q == ec_s1) samp_d[1] = RX_IN;
            if (edge_cnt_q == ec_s2) samp_d[2] = RX_IN;
            if (edge_cnt_q == ec_vote)
                sampled_bit_d = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                                (samp_q[1] & samp_q[2]);
        end

        case (state_q)
            ST_IDLE: begin
                edge_cnt_d = '0;
                if (!RX_IN) begin
                    state_d     = ST_START;
                    begin_frame = 1'b1;
                end
            end
            ST_START: begin
                if (last_edge) begin
                    state_d   = sampled_bit_q ? ST_IDLE : ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (edge_cnt_q == ec_act) p_data_d[bit_cnt_q] = sampled_bit_q;
                if (last_edge) begin
                    if (bit_cnt_q == BW'(DATA_WIDTH - 1))
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    else
                        bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
            ST_PARITY: begin
                if (edge_cnt_q == ec_act) begin
                    par_chk_en_c   = 1'b1;
                    par_err_flag_d = par_err_flag_q | par_err;
                end
                if (last_edge) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (edge_cnt_q == ec_act) stp_err_d = ~sampled_bit_q;
                // At Prescale 8 the stop sample and the frame end share one cycle,
                // so the valid decision uses the freshly computed stop error.
                if (last_edge) begin
                    data_valid_d = ~stp_err_d & ~par_err_flag_q;
                    if (!RX_IN) begin
                        state_d     = ST_START;
                        begin_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (begin_frame) begin
            edge_cnt_d     = '0;
            presc_d        = Prescale;
            par_en_d       = PAR_EN;
            par_typ_d      = PAR_TYP;
            par_err_flag_d = 1'b0;
            stp_err_d      = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q        <= ST_IDLE;
            edge_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            presc_q        <= '0;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            samp_q         <= '0;
            sampled_bit_q  <= 1'b0;
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            par_err_flag_q <= 1'b0;
            stp_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            edge_cnt_q     <= edge_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            presc_q        <= presc_d;
            par_en_q       <= par_en_d;
            par_typ_q      <= par_typ_d;
            samp_q         <= samp_d;
            sampled_bit_q  <= sampled_bit_d;
            p_data_q       <= p_data_d;
            data_valid_q   <= data_valid_d;
            par_err_flag_q <= par_err_flag_d;
            stp_err_q      <= stp_err_d;
        end
    end

    assign par_typ      = par_typ_q;
    assign par_chk_en   = par_chk_en_c;
    assign sampled_bit  = sampled_bit_q;
    assign P_DATA       = p_data_q;
    assign data_valid   = data_valid_q;
    assign par_err_flag = par_err_flag_q;
    assign stp_err      = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: vector table of single frames plus
// hand sequences for glitch rejection, back-to-back frames and mid-frame reset.
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [5:0] presc;
    logic       pe, pt, perr_cfg;
    logic       par_err;
    logic       par_typ, par_chk_en, sampled_bit, data_valid, par_err_flag, stp_err;
    logic [7:0] P_DATA;

    always #5 clk = ~clk;

    // Parity checker stand-in: reports the configured result only while strobed.
    assign par_err = perr_cfg & par_chk_en;

    uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK(clk), .RST(rst_n), .RX_IN(rx), .Prescale(presc), .PAR_EN(pe),
        .PAR_TYP(pt), .par_err(par_err), .par_typ(par_typ), .par_chk_en(par_chk_en),
        .sampled_bit(sampled_bit), .P_DATA(P_DATA), .data_valid(data_valid),
        .par_err_flag(par_err_flag), .stp_err(stp_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         dv_q[$];
    logic [7:0] dvpd_q[$];
    int         pc_q[$];

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (data_valid) begin
                dv_q.push_back(cyc);
                dvpd_q.push_back(P_DATA);
            end
            if (par_chk_en) pc_q.push_back(cyc);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_q();
        dv_q.delete();
        dvpd_q.delete();
        pc_q.delete();
    endtask

    // Edge index of the first driven bit is returned in start; a pulse seen at
    // cyc sits at offset cyc - start - 1 from the start-detect edge.
    task automatic send_frame(input int p, input logic [10:0] fr, input int nbits,
                              input int max_edges, output int start);
        start = cyc;
        for (int k = 0; k < nbits * p && k < max_edges; k++) begin
            rx = fr[k / p];
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] build(input logic [7:0] b, input logic en,
                                          input logic parbit, input logic stopbit);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
        if (en) begin
            f[9]  = parbit;
            f[10] = stopbit;
        end else begin
            f[9] = stopbit;
        end
        return f;
    endfunction

    typedef struct {
        int         p;
        logic       pe;
        logic       pt;
        logic [7:0] byt;
        logic       parbit;
        logic       stopbit;
        logic       perr;
        int         exp_dv;
        int         exp_cyc;
        logic [7:0] exp_pd;
        logic       exp_stp;
        logic       exp_pf;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int start, s1, s2;
        logic [10:0] fr;

        vecs[0] = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1, 80,  8'hA5, 1'b0, 1'b0};
        vecs[1] = '{16, 1'b1, 1'b0, 8'hB8, 1'b0, 1'b1, 1'b0, 1, 176, 8'hB8, 1'b0, 1'b0};
        vecs[2] = '{16, 1'b1, 1'b0, 8'hB8, 1'b0, 1'b1, 1'b1, 0, 0,   8'hB8, 1'b0, 1'b1};
        vecs[3] = '{8,  1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1, 88,  8'h00, 1'b0, 1'b0};
        vecs[4] = '{16, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1, 160, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{32, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 0, 0,   8'h3C, 1'b1, 1'b0};

        rst_n = 1'b0; rx = 1'b1; presc = 6'd8; pe = 1'b1; pt = 1'b1; perr_cfg = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_p_data", P_DATA, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_par_typ", par_typ, 0);
        chk("rst_flags", {par_err_flag, stp_err, par_chk_en, sampled_bit}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        for (int i = 0; i < 6; i++) begin
            presc = 6'(vecs[i].p); pe = vecs[i].pe; pt = vecs[i].pt; perr_cfg = vecs[i].perr;
            fr = build(vecs[i].byt, vecs[i].pe, vecs[i].parbit, vecs[i].stopbit);
            clear_q();
            send_frame(vecs[i].p, fr, vecs[i].pe ? 11 : 10, 1000, start);
            idle(4);
            chk($sformatf("v%0d_dv_count", i), dv_q.size(), vecs[i].exp_dv);
            if (vecs[i].exp_dv == 1 && dv_q.size() > 0)
                chk($sformatf("v%0d_dv_cycle", i), dv_q[0] - start - 1, vecs[i].exp_cyc);
            chk($sformatf("v%0d_p_data", i), P_DATA, vecs[i].exp_pd);
            chk($sformatf("v%0d_stp_err", i), stp_err, vecs[i].exp_stp);
            chk($sformatf("v%0d_par_err_flag", i), par_err_flag, vecs[i].exp_pf);
            chk($sformatf("v%0d_par_typ", i), par_typ, vecs[i].pt);
            chk($sformatf("v%0d_par_chk_cnt", i), pc_q.size(), vecs[i].pe ? 1 : 0);
            if (vecs[i].pe && pc_q.size() > 0)
                chk($sformatf("v%0d_par_chk_cycle", i), pc_q[0] - start - 1,
                    9 * vecs[i].p + vecs[i].p / 2 + 3);
        end

        // Start glitch: 3 low cycles must be rejected; also clears the earlier stp_err.
        presc = 6'd8; pe = 1'b0; pt = 1'b0; perr_cfg = 1'b0;
        clear_q();
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        idle(20);
        chk("glitch_dv_count", dv_q.size(), 0);
        chk("glitch_stp_err", stp_err, 0);
        chk("glitch_par_err_flag", par_err_flag, 0);
        chk("glitch_sampled_bit", sampled_bit, 1);
        chk("glitch_p_data_held", P_DATA, 8'h3C);

        // Back-to-back frames at P=32 with no idle gap.
        presc = 6'd32;
        clear_q();
        send_frame(32, build(8'h01, 1'b0, 1'b0, 1'b1), 10, 1000, s1);
        send_frame(32, build(8'hFE, 1'b0, 1'b0, 1'b1), 10, 1000, s2);
        idle(4);
        chk("b2b_dv_count", dv_q.size(), 2);
        if (dv_q.size() == 2) begin
            chk("b2b_first_cycle", dv_q[0] - s1 - 1, 320);
            chk("b2b_spacing", dv_q[1] - dv_q[0], 320);
            chk("b2b_first_byte", dvpd_q[0], 8'h01);
            chk("b2b_second_byte", dvpd_q[1], 8'hFE);
        end

        // Asynchronous reset in the middle of data bit 4.
        presc = 6'd16;
        clear_q();
        send_frame(16, build(8'h2C, 1'b0, 1'b0, 1'b1), 10, 5 * 16 + 8, start);
        chk("mid_p_data_partial", P_DATA, 8'hFC);
        chk("mid_sampled_bit", sampled_bit, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_p_data", P_DATA, 0);
        chk("mid_rst_outputs", {data_valid, par_err_flag, stp_err, par_chk_en, sampled_bit, par_typ}, 0);
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        clear_q();
        send_frame(16, build(8'h5A, 1'b0, 1'b0, 1'b1), 10, 1000, start);
        idle(4);
        chk("post_rst_dv_count", dv_q.size(), 1);
        if (dv_q.size() > 0) chk("post_rst_dv_cycle", dv_q[0] - start - 1, 160);
        chk("post_rst_p_data", P_DATA, 8'h5A);
        chk("post_rst_stp_err", stp_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
